// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_pkg
// Description : Shared FSM encoding, select-width helper and error read data
//               for the MMIO interconnect.
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } mmio_state_e;

  localparam int unsigned C_ERR_RDATA = 0;

  // A single-slave build still needs a one-bit index to stay legal.
  function automatic int unsigned sel_width(input int unsigned n_slaves);
    return (n_slaves > 1) ? $clog2(n_slaves) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_timeout.sv
`default_nettype none
// ============================================================================
// Module      : mmio_timeout
// Description : Access-phase watchdog (clear/enable/expired). Instantiated only
//               when MMIO_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_timeout #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires in the cycle whose increment brings the count up to LIMIT.
  assign expired_o = en_i && (cnt_q == CNT_W'(LIMIT - 1));

endmodule
`default_nettype wire

// File: rtl/mmio_interconnect.sv
`default_nettype none
// ============================================================================
// Module      : mmio_interconnect
// Description : Single-master, N-slave MMIO decoder with one outstanding
//               transaction. Define MMIO_TIMEOUT_EN to enable the ack watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_interconnect
  import mmio_pkg::*;
#(
  parameter int unsigned          N_SLAVES   = 8,
  parameter int unsigned          ADDR_W     = 32,
  parameter int unsigned          DATA_W     = 32,
  parameter logic [N_SLAVES-1:0]  SLAVE_MASK = '1,
  parameter int unsigned          TIMEOUT    = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m_valid,
  output logic                         m_ready,
  input  logic [ADDR_W-1:0]            m_addr,
  input  logic [DATA_W-1:0]            m_wdata,
  input  logic [DATA_W/8-1:0]          m_wstrb,
  input  logic                         m_we,
  output logic                         m_resp_valid,
  output logic [DATA_W-1:0]            m_rdata,
  output logic                         m_err,
  output logic [N_SLAVES-1:0]          s_sel,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  output logic [DATA_W/8-1:0]          s_wstrb,
  output logic                         s_we,
  input  logic [N_SLAVES-1:0]          s_ack,
  input  logic [N_SLAVES*DATA_W-1:0]   s_rdata
);

  localparam int unsigned SEL_W  = sel_width(N_SLAVES);
  localparam int unsigned STRB_W = DATA_W / 8;

  mmio_state_e         state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                we_q, we_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [SEL_W-1:0]    w_idx;
  logic                w_accept;
  logic                w_ack;
  logic                w_expired;
  logic [DATA_W-1:0]   w_slave_rdata [N_SLAVES];

  for (genvar k = 0; k < N_SLAVES; k++) begin : g_rdata
    assign w_slave_rdata[k] = s_rdata[k*DATA_W +: DATA_W];
  end

  assign w_idx    = m_addr[ADDR_W-1 -: SEL_W];
  assign w_accept = m_valid && m_ready;
  // Only the addressed slave's ack is observed; strays are dropped here.
  assign w_ack    = s_ack[idx_q];

`ifdef MMIO_TIMEOUT_EN
  logic w_tmo_en;

  assign w_tmo_en = (state_q == ST_ACCESS) && !w_ack;

  mmio_timeout #(
    .LIMIT     (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (w_accept),
    .en_i      (w_tmo_en),
    .expired_o (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    we_d    = we_q;
    idx_d   = idx_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          addr_d  = m_addr;
          wdata_d = m_wdata;
          wstrb_d = m_wstrb;
          we_d    = m_we;
          idx_d   = w_idx;
          if (SLAVE_MASK[w_idx]) begin
            state_d = ST_ACCESS;
          end else begin
            rdata_d = DATA_W'(C_ERR_RDATA);
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_ACCESS: begin
        // Ack takes priority over an expiry landing in the same cycle.
        if (w_ack) begin
          rdata_d = w_slave_rdata[idx_q];
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (w_expired) begin
          rdata_d = DATA_W'(C_ERR_RDATA);
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign m_ready      = (state_q == ST_IDLE) && !rst;
  assign m_resp_valid = (state_q == ST_RESP) && !rst;
  assign m_err        = m_resp_valid && err_q;
  assign m_rdata      = rdata_q;

  assign s_sel   = ((state_q == ST_ACCESS) && !rst) ? (N_SLAVES'(1) << idx_q) : '0;
  assign s_addr  = addr_q;
  assign s_wdata = wdata_q;
  assign s_we    = we_q;
  assign s_wstrb = we_q ? wstrb_q : '0;

endmodule
`default_nettype wire
